// File: rtl/axi4_lite_master_bridge.sv
// axi4_lite_master_bridge: core-side write/read requests to an AXI4-Lite master with independent channel FSMs
module axi4_lite_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write_start,
  input  logic [ADDR_WIDTH-1:0]   write_addr,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strobe,
  output logic                    write_busy,
  output logic                    write_err,
  input  logic                    read_start,
  input  logic [ADDR_WIDTH-1:0]   read_addr,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_busy,
  output logic                    read_err,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  w_state_t                w_state_q;
  r_state_t                r_state_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    awvalid_q, wvalid_q, bready_q, write_err_q;
  logic                    arvalid_q, rready_q, read_err_q;
  // AW and W may complete in either order; each valid drops independently
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q   <= W_IDLE;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      write_err_q <= 1'b0;
    end else begin
      write_err_q <= 1'b0;
      case (w_state_q)
        W_IDLE: if (write_start) begin
          awaddr_q  <= write_addr;
          wdata_q   <= write_data;
          wstrb_q   <= write_strobe;
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          w_state_q <= W_REQ;
        end
        W_REQ: begin
          if (m_axi_awready) awvalid_q <= 1'b0;
          if (m_axi_wready) wvalid_q <= 1'b0;
          if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
            bready_q  <= 1'b1;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: if (m_axi_bvalid) begin
          bready_q    <= 1'b0;
          write_err_q <= m_axi_bresp != 2'b00;
          w_state_q   <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q  <= R_IDLE;
      araddr_q   <= '0;
      rdata_q    <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      read_err_q <= 1'b0;
    end else begin
      read_err_q <= 1'b0;
      case (r_state_q)
        R_IDLE: if (read_start) begin
          araddr_q  <= read_addr;
          arvalid_q <= 1'b1;
          r_state_q <= R_ADDR;
        end
        R_ADDR: if (m_axi_arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          r_state_q <= R_DATA;
        end
        R_DATA: if (m_axi_rvalid) begin
          rdata_q    <= m_axi_rdata;
          read_err_q <= m_axi_rresp != 2'b00;
          rready_q   <= 1'b0;
          r_state_q  <= R_IDLE;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end
  assign write_busy    = write_start || (w_state_q != W_IDLE);
  assign read_busy     = read_start || (r_state_q != R_IDLE);
  assign write_err     = write_err_q;
  assign read_err      = read_err_q;
  assign read_data     = rdata_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// tb_axi4_lite_master_bridge: directed cycle-by-cycle checks of the AXI4-Lite master bridge
module tb_axi4_lite_master_bridge;
  logic        clk = 1'b0, rst = 1'b1;
  logic        write_start = 0, read_start = 0;
  logic [31:0] write_addr = 0, write_data = 0, read_addr = 0;
  logic [3:0]  write_strobe = 0;
  logic        write_busy, write_err, read_busy, read_err;
  logic [31:0] read_data;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [1:0]  bresp = 0, rresp = 0;
  logic [31:0] rdata = 0;
  int          n_cmp = 0, n_bad = 0;

  axi4_lite_master_bridge dut (
    .clk(clk), .rst(rst),
    .write_start(write_start), .write_addr(write_addr), .write_data(write_data),
    .write_strobe(write_strobe), .write_busy(write_busy), .write_err(write_err),
    .read_start(read_start), .read_addr(read_addr), .read_data(read_data),
    .read_busy(read_busy), .read_err(read_err),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge; callers then drive inputs and wait #1 before checking
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(); cyc();
    #1;
    chk("rst awvalid", awvalid, 0); chk("rst wvalid", wvalid, 0); chk("rst bready", bready, 0);
    chk("rst arvalid", arvalid, 0); chk("rst rready", rready, 0); chk("rst read_data", read_data, 0);
    chk("rst awaddr", awaddr, 0); chk("rst errs", {write_err, read_err}, 0);
    chk("prot", {awprot, arprot}, 0);
    rst = 0;
    // simple write, always-ready slave
    cyc();
    write_start = 1; write_addr = 32'h1000_0004; write_data = 32'hCAFE_BABE; write_strobe = 4'hF;
    awready = 1; wready = 1; #1;
    chk("w0 busy", write_busy, 1); chk("w0 awvalid", awvalid, 0);
    cyc(); write_start = 0; #1;
    chk("w1 valids", {awvalid, wvalid, bready}, 3'b110);
    chk("w1 awaddr", awaddr, 32'h1000_0004); chk("w1 wdata", wdata, 32'hCAFE_BABE); chk("w1 wstrb", wstrb, 4'hF);
    cyc(); bvalid = 1; bresp = 0; #1;
    chk("w2 valids", {awvalid, wvalid, bready}, 3'b001); chk("w2 busy", write_busy, 1);
    cyc(); bvalid = 0; #1;
    chk("w3 busy", write_busy, 0); chk("w3 err", write_err, 0); chk("w3 bready", bready, 0);
    // skewed handshakes: W first, AW late, error response
    cyc();
    write_start = 1; write_addr = 32'h40; write_data = 32'h1122_3344; write_strobe = 4'h3;
    awready = 0; wready = 1; #1;
    cyc(); write_start = 0; #1;
    chk("s1 valids", {awvalid, wvalid}, 2'b11);
    cyc(); wready = 0; #1;
    chk("s2 valids", {awvalid, wvalid, bready}, 3'b100);
    cyc(); #1;
    chk("s3 awvalid", awvalid, 1); chk("s3 awaddr", awaddr, 32'h40);
    cyc(); awready = 1; #1;
    chk("s4 awvalid", awvalid, 1); chk("s4 bready", bready, 0);
    cyc(); awready = 0; #1;
    chk("s5 valids", {awvalid, wvalid, bready}, 3'b001);
    cyc(); bvalid = 1; bresp = 2'b11; #1;
    chk("s6 busy", write_busy, 1); chk("s6 err", write_err, 0);
    cyc(); bvalid = 0; bresp = 0; #1;
    chk("s7 busy", write_busy, 0); chk("s7 err", write_err, 1);
    cyc(); #1;
    chk("s8 err", write_err, 0);
    // read with late arready and SLVERR
    cyc(); read_start = 1; read_addr = 32'h2000_0000; arready = 0; #1;
    chk("r0 busy", read_busy, 1);
    for (int i = 1; i <= 3; i++) begin
      cyc(); read_start = 0; #1;
      chk("r arvalid held", arvalid, 1); chk("r araddr", araddr, 32'h2000_0000);
    end
    cyc(); arready = 1; #1;
    chk("r4 rready", rready, 0);
    cyc(); arready = 0; rvalid = 1; rdata = 32'h1234_5678; rresp = 2'b10; #1;
    chk("r5 arvalid", arvalid, 0); chk("r5 rready", rready, 1); chk("r5 busy", read_busy, 1);
    cyc(); rvalid = 0; rdata = 0; rresp = 0; #1;
    chk("r6 data", read_data, 32'h1234_5678); chk("r6 err", read_err, 1);
    chk("r6 busy", read_busy, 0); chk("r6 rready", rready, 0);
    cyc(); #1;
    chk("r7 err", read_err, 0); chk("r7 data hold", read_data, 32'h1234_5678);
    // concurrent write and read, with ignored restarts
    cyc();
    write_start = 1; write_addr = 32'h3000; write_data = 32'hA5A5_A5A5; write_strobe = 4'hC;
    read_start = 1; read_addr = 32'h5000; awready = 1; wready = 1; arready = 0; #1;
    chk("c0 busy", {write_busy, read_busy}, 2'b11);
    cyc();
    write_start = 1; write_addr = 32'h7777; write_data = 32'h0; write_strobe = 4'h1;
    read_start = 1; read_addr = 32'h6000; #1;
    chk("c1 valids", {awvalid, wvalid, arvalid}, 3'b111); chk("c1 araddr", araddr, 32'h5000);
    cyc(); write_start = 0; read_start = 0; bvalid = 1; arready = 1; #1;
    chk("c2 araddr", araddr, 32'h5000); chk("c2 bready", bready, 1);
    chk("c2 awaddr", awaddr, 32'h3000); chk("c2 wdata", wdata, 32'hA5A5_A5A5); chk("c2 wstrb", wstrb, 4'hC);
    cyc(); bvalid = 0; arready = 0; rvalid = 1; rdata = 32'hDEAD_BEEF; #1;
    chk("c3 wbusy", write_busy, 0); chk("c3 werr", write_err, 0);
    chk("c3 rready", rready, 1); chk("c3 arvalid", arvalid, 0); chk("c3 rbusy", read_busy, 1);
    cyc(); rvalid = 0; #1;
    chk("c4 data", read_data, 32'hDEAD_BEEF); chk("c4 rerr", read_err, 0); chk("c4 rbusy", read_busy, 0);
    // reset while waiting for B
    cyc();
    write_start = 1; write_addr = 32'h8000; write_data = 32'h1; write_strobe = 4'h1; awready = 1; wready = 1; #1;
    cyc(); write_start = 0; #1;
    chk("x1 awvalid", awvalid, 1);
    cyc(); #1;
    chk("x2 bready", bready, 1);
    rst = 1; bvalid = 1; bresp = 2'b10; read_start = 1; read_addr = 32'hBAD0;
    cyc(); rst = 0; bvalid = 0; bresp = 0; read_start = 0; #1;
    chk("x3 valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("x3 busy", {write_busy, read_busy}, 0); chk("x3 errs", {write_err, read_err}, 0);
    chk("x3 awaddr", awaddr, 0); chk("x3 read_data", read_data, 0);
    cyc();
    write_start = 1; write_addr = 32'h9000; write_data = 32'h55AA_55AA; write_strobe = 4'hF; #1;
    cyc(); write_start = 0; #1;
    chk("f1 awaddr", awaddr, 32'h9000); chk("f1 wdata", wdata, 32'h55AA_55AA);
    chk("f1 valids", {awvalid, wvalid}, 2'b11);
    cyc(); bvalid = 1; #1;
    chk("f2 bready", bready, 1);
    cyc(); bvalid = 0; #1;
    chk("f3 busy", write_busy, 0); chk("f3 err", write_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
